// File: rtl/mlp_batch_eval_if.sv
// Bundle of the batch-control, MLP-core and label-memory signals that
// surround the batch sequencer. "master" is the sequencer side and
// "slave" is the environment side (MLP core, label memory, controller).
interface mlp_batch_eval_if #(
    parameter int ADDR_W  = 10,
    parameter int CLASS_W = 4,
    parameter int CNT_W   = 10
);
    logic               go;
    logic [ADDR_W-1:0]  first_idx;
    logic [CNT_W-1:0]   num_tests;
    logic               mlp_rst;
    logic               mlp_start;
    logic [ADDR_W-1:0]  mlp_test_num;
    logic [CLASS_W-1:0] mlp_out;
    logic               mlp_done;
    logic               label_rd;
    logic [ADDR_W-1:0]  label_addr;
    logic [CLASS_W-1:0] label_in;
    logic               busy;
    logic               batch_done;
    logic [CNT_W-1:0]   correct_cnt;
    logic [CNT_W-1:0]   total_cnt;
    logic [CNT_W-1:0]   timeout_cnt;
    logic [CLASS_W-1:0] last_pred;

    modport master (
        input  go, first_idx, num_tests, mlp_out, mlp_done, label_in,
        output mlp_rst, mlp_start, mlp_test_num, label_rd, label_addr,
               busy, batch_done, correct_cnt, total_cnt, timeout_cnt, last_pred
    );

    modport slave (
        output go, first_idx, num_tests, mlp_out, mlp_done, label_in,
        input  mlp_rst, mlp_start, mlp_test_num, label_rd, label_addr,
               busy, batch_done, correct_cnt, total_cnt, timeout_cnt, last_pred
    );
endinterface

// File: rtl/mlp_batch_eval.sv
// Batch sequencer and scorer for the MLP core: walks a range of test
// indices, resets and starts the core for each one, waits for done (or a
// timeout), compares the prediction against the label memory and keeps
// correct / total / timeout counts for the whole batch.
module mlp_batch_eval #(
    parameter int N_TESTS = 750,
    parameter int ADDR_W  = 10,
    parameter int CLASS_W = 4,
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mlp_batch_eval_if.master  bus
);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(N_TESTS - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MRST  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t             state_reg;
    logic [ADDR_W-1:0]  idx_reg;
    logic [CNT_W-1:0]   remaining_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic               timed_out_reg;
    logic               busy_reg;
    logic               label_rd_reg;
    logic               batch_done_reg;
    logic               mlp_start_reg;
    logic [CNT_W-1:0]   correct_reg;
    logic [CNT_W-1:0]   total_reg;
    logic [CNT_W-1:0]   timeout_reg;
    logic [CLASS_W-1:0] last_pred_reg;

    // The core reset is the only combinational output so that a system
    // reset reaches the MLP core in the same cycle.
    assign bus.mlp_rst      = rst | (state_reg == MRST);
    assign bus.mlp_start    = mlp_start_reg;
    assign bus.mlp_test_num = idx_reg;
    assign bus.label_addr   = idx_reg;
    assign bus.label_rd     = label_rd_reg;
    assign bus.busy         = busy_reg;
    assign bus.batch_done   = batch_done_reg;
    assign bus.correct_cnt  = correct_reg;
    assign bus.total_cnt    = total_reg;
    assign bus.timeout_cnt  = timeout_reg;
    assign bus.last_pred    = last_pred_reg;

    // Batch FSM: per inference MRST -> START -> WAIT(k) -> CHECK, k+3 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            remaining_reg  <= '0;
            timer_reg      <= '0;
            timed_out_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            label_rd_reg   <= 1'b0;
            batch_done_reg <= 1'b0;
            mlp_start_reg  <= 1'b0;
            correct_reg    <= '0;
            total_reg      <= '0;
            timeout_reg    <= '0;
            last_pred_reg  <= '0;
        end else begin
            mlp_start_reg  <= 1'b0;
            batch_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.go) begin
                        // Out-of-range start indices fall back to entry 0.
                        idx_reg       <= (bus.first_idx > LAST_IDX) ? '0 : bus.first_idx;
                        remaining_reg <= bus.num_tests;
                        correct_reg   <= '0;
                        total_reg     <= '0;
                        timeout_reg   <= '0;
                        busy_reg      <= 1'b1;
                        label_rd_reg  <= 1'b1;
                        state_reg     <= (bus.num_tests == '0) ? FIN : MRST;
                    end
                end
                MRST: begin
                    mlp_start_reg <= 1'b1;
                    state_reg     <= START;
                end
                START: begin
                    timer_reg <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    timer_reg <= timer_reg + TIMER_W'(1);
                    // A done seen on the last allowed cycle still counts as done.
                    if (bus.mlp_done) begin
                        timed_out_reg <= 1'b0;
                        state_reg     <= CHECK;
                    end else if (timer_reg == TIMER_LAST) begin
                        timed_out_reg <= 1'b1;
                        state_reg     <= CHECK;
                    end
                end
                CHECK: begin
                    total_reg <= total_reg + CNT_W'(1);
                    if (timed_out_reg) begin
                        timeout_reg <= timeout_reg + CNT_W'(1);
                    end else begin
                        last_pred_reg <= bus.mlp_out;
                        if (bus.mlp_out == bus.label_in) begin
                            correct_reg <= correct_reg + CNT_W'(1);
                        end
                    end
                    remaining_reg <= remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_reg <= FIN;
                    end else begin
                        idx_reg   <= (idx_reg == LAST_IDX) ? '0 : idx_reg + ADDR_W'(1);
                        state_reg <= MRST;
                    end
                end
                FIN: begin
                    batch_done_reg <= 1'b1;
                    busy_reg       <= 1'b0;
                    label_rd_reg   <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_batch_eval.sv
// Directed bench for mlp_batch_eval: behavioural MLP core (done 160 cycles
// after start, prediction = idx % 10), label memory = idx % 10 with optional
// corruption, a table of batches plus hand-written reset / empty-batch cases.
module tb_mlp_batch_eval;
    localparam int ADDR_W  = 10;
    localparam int CLASS_W = 4;
    localparam int CNT_W   = 10;
    localparam int MLP_LAT = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mlp_batch_eval_if #(.ADDR_W(ADDR_W), .CLASS_W(CLASS_W), .CNT_W(CNT_W)) bus ();

    mlp_batch_eval #(
        .N_TESTS(750), .ADDR_W(ADDR_W), .CLASS_W(CLASS_W), .CNT_W(CNT_W), .TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- MLP core and label memory models ----------------
    int                hang_idx = -1;
    bit                corrupt  = 1'b0;
    logic [ADDR_W-1:0] cur_idx  = '0;
    logic              running  = 1'b0;
    logic              done_q   = 1'b0;
    int                lat_cnt  = 0;

    always @(posedge clk) begin
        if (bus.mlp_rst) begin
            running <= 1'b0;
            done_q  <= 1'b0;
            lat_cnt <= 0;
        end else if (bus.mlp_start) begin
            running <= 1'b1;
            done_q  <= 1'b0;
            lat_cnt <= 0;
            cur_idx <= bus.mlp_test_num;
        end else if (running && !done_q) begin
            lat_cnt <= lat_cnt + 1;
            if (lat_cnt == MLP_LAT - 1 && int'(cur_idx) != hang_idx) done_q <= 1'b1;
        end
    end

    assign bus.mlp_done = done_q;
    assign bus.mlp_out  = CLASS_W'(cur_idx % 10);

    logic [CLASS_W-1:0] label_val;
    always_comb begin
        label_val = CLASS_W'(bus.label_addr % 10);
        if (corrupt && (bus.label_addr == 10'd6 || bus.label_addr == 10'd8)) label_val = 4'hF;
    end
    assign bus.label_in = label_val;

    // ---------------- Output monitor (sampled on falling edge) ----------------
    int idx_q[$];
    int lp_q[$];
    int dly_q[$];
    int cyc         = 0;
    int start_cyc   = 0;
    bit timing      = 1'b0;
    bit prev_bd     = 1'b0;
    int done_pulses = 0;
    int bad_addr    = 0;
    int bad_rd      = 0;
    int bad_bd_busy = 0;
    int bad_bd_wide = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            timing = 1'b0;
        end else begin
            if (bus.mlp_start) begin
                idx_q.push_back(int'(bus.mlp_test_num));
                lp_q.push_back(int'(bus.last_pred));
                start_cyc = cyc;
                timing    = 1'b1;
            end
            // Start of one inference to core reset of the next = WAIT cycles + 2.
            if (bus.mlp_rst && timing) begin
                dly_q.push_back(cyc - start_cyc);
                timing = 1'b0;
            end
            if (bus.batch_done) begin
                done_pulses++;
                timing = 1'b0;
                if (bus.busy) bad_bd_busy++;
                if (prev_bd) bad_bd_wide++;
            end
        end
        if (bus.label_addr != bus.mlp_test_num) bad_addr++;
        if (bus.label_rd != bus.busy) bad_rd++;
        prev_bd = bus.batch_done;
    end

    // ---------------- Batch vector table ----------------
    typedef struct packed {
        int              first;
        int              num;
        bit              corrupt;
        int              hang;
        bit              poke;
        logic [3:0][9:0] exp_idx;
        int              exp_correct;
        int              exp_total;
        int              exp_timeout;
        int              exp_last;
        int              exp_lp_last_start;
        int              dly_pos;
    } vec_t;

    function automatic vec_t mk(input int first, input int num, input bit cor, input int hang,
                                input bit poke, input int i0, input int i1, input int i2,
                                input int i3, input int ec, input int et, input int eto,
                                input int el, input int elp, input int dpos);
        vec_t v;
        v.first = first; v.num = num; v.corrupt = cor; v.hang = hang; v.poke = poke;
        v.exp_idx[0] = 10'(i0); v.exp_idx[1] = 10'(i1);
        v.exp_idx[2] = 10'(i2); v.exp_idx[3] = 10'(i3);
        v.exp_correct = ec; v.exp_total = et; v.exp_timeout = eto;
        v.exp_last = el; v.exp_lp_last_start = elp; v.dly_pos = dpos;
        return v;
    endfunction

    vec_t vecs[5];

    task automatic run_batch(input vec_t v);
        int ib, db, pb, n;
        corrupt  = v.corrupt;
        hang_idx = v.hang;
        ib = idx_q.size();
        db = dly_q.size();
        pb = done_pulses;
        @(negedge clk);
        bus.go        = 1'b1;
        bus.first_idx = ADDR_W'(v.first);
        bus.num_tests = CNT_W'(v.num);
        @(negedge clk);
        bus.go = 1'b0;
        chk("busy_after_go", int'(bus.busy), 1);
        if (v.poke) begin
            // A go while busy must not disturb the running batch.
            repeat (50) @(negedge clk);
            bus.go        = 1'b1;
            bus.first_idx = 10'd100;
            bus.num_tests = 10'd1;
            @(negedge clk);
            bus.go = 1'b0;
        end
        n = 0;
        while (!bus.batch_done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("batch_done_seen", int'(bus.batch_done), 1);
        chk("correct_cnt", int'(bus.correct_cnt), v.exp_correct);
        chk("total_cnt", int'(bus.total_cnt), v.exp_total);
        chk("timeout_cnt", int'(bus.timeout_cnt), v.exp_timeout);
        chk("last_pred", int'(bus.last_pred), v.exp_last);
        chk("num_starts", idx_q.size() - ib, v.num);
        for (int i = 0; i < v.num && i < 4; i++) begin
            chk("test_idx", idx_q[ib + i], int'(v.exp_idx[i]));
        end
        chk("last_pred_at_last_start", lp_q[ib + v.num - 1], v.exp_lp_last_start);
        if (v.dly_pos >= 0) chk("timeout_wait_len", dly_q[db + v.dly_pos], 257);
        repeat (3) @(negedge clk);
        chk("batch_done_pulses", done_pulses - pb, 1);
        chk("batch_done_low", int'(bus.batch_done), 0);
        $display("batch first=%0d num=%0d correct=%0d total=%0d timeout=%0d last_pred=%0d",
                 v.first, v.num, bus.correct_cnt, bus.total_cnt, bus.timeout_cnt, bus.last_pred);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ib, pb, n;
        vecs[0] = mk(5,   4, 1'b0, -1, 1'b1, 5,   6,   7, 8, 4, 4, 0, 8, 7, -1);
        vecs[1] = mk(5,   4, 1'b1, -1, 1'b0, 5,   6,   7, 8, 2, 4, 0, 8, 7, -1);
        vecs[2] = mk(748, 4, 1'b0, -1, 1'b0, 748, 749, 0, 1, 4, 4, 0, 1, 0, -1);
        vecs[3] = mk(9,   3, 1'b0, 10, 1'b0, 9,   10, 11, 0, 2, 3, 1, 1, 9, 1);
        vecs[4] = mk(800, 2, 1'b0, -1, 1'b0, 0,   1,   0, 0, 2, 2, 0, 1, 0, -1);

        bus.go = 1'b0;
        bus.first_idx = '0;
        bus.num_tests = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_batch_done", int'(bus.batch_done), 0);
        chk("rst_mlp_start", int'(bus.mlp_start), 0);
        chk("rst_label_rd", int'(bus.label_rd), 0);
        chk("rst_correct", int'(bus.correct_cnt), 0);
        chk("rst_total", int'(bus.total_cnt), 0);
        chk("rst_timeout", int'(bus.timeout_cnt), 0);
        chk("rst_last_pred", int'(bus.last_pred), 0);
        chk("rst_test_num", int'(bus.mlp_test_num), 0);
        chk("rst_mlp_rst", int'(bus.mlp_rst), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_mlp_rst", int'(bus.mlp_rst), 0);

        for (int v = 0; v < 5; v++) run_batch(vecs[v]);

        // Empty batch, plus a go during FIN that must be ignored.
        ib = idx_q.size();
        pb = done_pulses;
        @(negedge clk);
        bus.go = 1'b1; bus.first_idx = 10'd3; bus.num_tests = 10'd0;
        @(negedge clk);
        chk("empty_busy", int'(bus.busy), 1);
        chk("empty_bd_early", int'(bus.batch_done), 0);
        bus.go = 1'b1; bus.first_idx = 10'd7; bus.num_tests = 10'd5;
        @(negedge clk);
        bus.go = 1'b0;
        chk("empty_bd", int'(bus.batch_done), 1);
        chk("empty_busy_end", int'(bus.busy), 0);
        @(negedge clk);
        chk("empty_bd_low", int'(bus.batch_done), 0);
        repeat (5) @(negedge clk);
        chk("empty_no_restart", int'(bus.busy), 0);
        chk("empty_no_starts", idx_q.size() - ib, 0);
        chk("empty_pulses", done_pulses - pb, 1);
        chk("empty_correct", int'(bus.correct_cnt), 0);
        chk("empty_total", int'(bus.total_cnt), 0);
        chk("empty_timeout", int'(bus.timeout_cnt), 0);
        chk("empty_last_pred", int'(bus.last_pred), 1);
        $display("batch first=3 num=0 correct=%0d total=%0d timeout=%0d",
                 bus.correct_cnt, bus.total_cnt, bus.timeout_cnt);

        // Reset during WAIT of the second inference.
        corrupt = 1'b0; hang_idx = -1;
        ib = idx_q.size();
        pb = done_pulses;
        @(negedge clk);
        bus.go = 1'b1; bus.first_idx = 10'd5; bus.num_tests = 10'd4;
        @(negedge clk);
        bus.go = 1'b0;
        n = 0;
        while (idx_q.size() - ib < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_seq_second_start", idx_q.size() - ib, 2);
        repeat (20) @(negedge clk);
        chk("pre_rst_total", int'(bus.total_cnt), 1);
        chk("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_mlp_rst", int'(bus.mlp_rst), 1);
        @(negedge clk);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_total", int'(bus.total_cnt), 0);
        chk("mid_rst_correct", int'(bus.correct_cnt), 0);
        chk("mid_rst_last_pred", int'(bus.last_pred), 0);
        chk("mid_rst_test_num", int'(bus.mlp_test_num), 0);
        chk("mid_rst_mlp_rst_held", int'(bus.mlp_rst), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", int'(bus.busy), 0);
        chk("post_rst_no_done", done_pulses - pb, 0);
        $display("reset mid-batch total=%0d busy=%0d", bus.total_cnt, bus.busy);

        run_batch(vecs[0]);

        chk("label_addr_tracks", bad_addr, 0);
        chk("label_rd_tracks_busy", bad_rd, 0);
        chk("busy_low_at_done", bad_bd_busy, 0);
        chk("done_single_cycle", bad_bd_wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mlp_batch_eval.md
Name: mlp_batch_eval

Overview:
Hardware batch sequencer and scorer around the MLP core. It issues test indices to the MLP and pulses its start. It waits for done, compares the predicted class against the label memory and accumulates correct/total/timeout counts. It replaces the per-run reset/start/compare loop with synthesizable logic so that accuracy over a batch of the 750-entry test set is measured on-chip.

Parameters:
N_TESTS, 750, number of entries in test/label memories; index wraps at this value
ADDR_W, 10, test index / label address width
CLASS_W, 4, class label and prediction width
CNT_W, 10, width of num_tests and all result counters
TIMEOUT, 255, maximum WAIT cycles per inference before it is declared timed out (nominal MLP latency ~160 cycles)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
go  in  1  single-cycle request to start a batch; sampled only in IDLE
first_idx  in  ADDR_W  first test index, captured on accepted go
num_tests  in  CNT_W  number of inferences in batch, captured on accepted go
mlp_rst  out  1  reset to MLP core
mlp_start  out  1  start pulse to MLP core
mlp_test_num  out  ADDR_W  test index presented to MLP
mlp_out  in  CLASS_W  MLP predicted class
mlp_done  in  1  MLP completion flag (level; cleared by mlp_rst)
label_rd  out  1  label memory read enable
label_addr  out  ADDR_W  label memory address (combinational-read memory)
label_in  in  CLASS_W  label data for label_addr
busy  out  1  batch in progress
batch_done  out  1  one-cycle pulse at batch end
correct_cnt  out  CNT_W  inferences with mlp_out == label_in
total_cnt  out  CNT_W  inferences completed, including timeouts
timeout_cnt  out  CNT_W  inferences that timed out
last_pred  out  CLASS_W  prediction of most recent completed inference

Behaviour:
- Reset: state IDLE; busy=0, batch_done=0, mlp_start=0, label_rd=0, all counters=0, last_pred=0, mlp_test_num=label_addr=0, wait timer=0.
- mlp_rst = rst OR (state==MRST); this is the only combinational output.
- States: IDLE, MRST, START, WAIT, CHECK, FIN.
- IDLE: go=1 -> capture idx = (first_idx >= N_TESTS) ? 0 : first_idx and remaining = num_tests. Clear correct/total/timeout counts. busy=1.
  - If num_tests==0, go to FIN; otherwise go to MRST.
  - go=0 -> stay in IDLE.
- MRST (1 cycle): mlp_rst=1, mlp_test_num=idx; next START.
- START (1 cycle): mlp_start=1, mlp_test_num=idx held; timer cleared; next WAIT.
- WAIT:
  - Timer increments each cycle.
  - If mlp_done=1, go to CHECK with timed_out=0. mlp_done takes priority over timeout on the same cycle.
  - Else if timer == TIMEOUT-1, go to CHECK with timed_out=1.
- CHECK (1 cycle):
  - total_cnt++.
  - If timed_out, timeout_cnt++ and last_pred is unchanged.
  - Else last_pred <= mlp_out, and correct_cnt++ if mlp_out == label_in.
  - remaining--. If remaining becomes 0, go to FIN.
  - Otherwise idx <= (idx == N_TESTS-1) ? 0 : idx+1, then go to MRST.
- FIN (1 cycle): batch_done=1, busy=0 from the next cycle; return to IDLE.
- label_addr = mlp_test_num at all times. label_rd=1 whenever busy.
- Per-inference latency = k+3 cycles, where k = WAIT cycles (k ≤ TIMEOUT).
- go while busy is ignored. Counts hold their final values until the next accepted go.
- num_tests > N_TESTS is legal: indices wrap and repeat. Counters cannot overflow because total ≤ num_tests ≤ 2^CNT_W-1.
- rst mid-batch: everything returns to reset values on the next edge. mlp_rst is asserted for the duration of rst. No batch_done pulse is issued.
- mlp_done=1 in any state other than WAIT is ignored.

Test Plan:
- Behavioural MLP model (done 160 cycles after start, out = idx%10); label model = idx%10. go with first_idx=5, num_tests=4 -> indices 5,6,7,8 presented in order; correct=4, total=4, timeout=0; batch_done is a single pulse; busy high from the cycle after go through FIN.
- Same setup but labels for idx 6 and 8 corrupted -> correct=2, total=4, last_pred=8.
- first_idx=748, num_tests=4 -> indices 748, 749, 0, 1; wrap verified on mlp_test_num and label_addr.
- Model never raises done for idx 10; first_idx=9, num_tests=3 -> WAIT lasts exactly 255 cycles for idx 10; timeout=1, total=3, correct=2; last_pred stays at idx 9's value until idx 11 completes.
- num_tests=0 -> batch_done 2 cycles after go; all counts 0; mlp_start never asserted. go pulsed while busy -> no effect on counts or index.
- rst asserted during WAIT of the 2nd inference -> next cycle IDLE, counters 0, busy=0, no batch_done. A subsequent go runs a clean batch.
